sb_rx_header_decoder: RTL
=========================

// Module: sb_rx_header_decoder
// PURPOSE
// - Sideband RX-path decoder: takes 64-bit sideband words from the RX deserializer and recovers the LTSM message view: msg_no, msg_info and optional 64-bit data.
// - Mirror of the TX header encoder; decoding depends on the local LTSM state, sub-state and point/sweep test context.
// - Validates each header and sequences message-with-data (header word, then data word).
// - Sits between the SB RX deserializer and the LTSM / point-sweep test controllers.
// PARAMETERS
// - DATA_TIMEOUT  32    cycles allowed in WAIT_DATA before abandoning a message-with-data
// - TMO_W         6     width of the timeout counter; must satisfy 2^TMO_W > DATA_TIMEOUT
// PORTS
// - i_clk                     in   1   clock
// - i_rst_n                   in   1   asynchronous, active-low reset
// - i_packet                  in   64  received sideband word; header in bits [61:0], [63:62] ignored
// - i_packet_valid            in   1   i_packet valid this cycle (single-cycle strobe per word)
// - i_state                   in   4   local LTSM state (SBINIT=2, MBINIT=3, MBTRAIN=4, TRAINERROR_HS=7, PHYRETRAIN=10)
// - i_sub_state               in   4   local sub-state (MBINIT 0..5, MBTRAIN 0..12)
// - i_tx_point_sweep_test_en  in   1   point/sweep test context active
// - i_tx_point_sweep_test     in   2   0=TX_PT, 1=TX_SWEEP, 2=RX_PT, 3=RX_SWEEP
// - o_msg_no                  out  4   decoded message number
// - o_msg_info                out  3   decoded message info
// - o_data                    out  64  payload of a message-with-data
// - o_msg_valid               out  1   1-cycle pulse: o_msg_no / o_msg_info valid
// - o_data_valid              out  1   1-cycle pulse coincident with o_msg_valid when o_data carries payload
// - o_decode_err              out  1   1-cycle pulse: header rejected or data timeout
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, timeout counter 0.
// - Reset is asynchronous; assertion mid-message discards any latched header and produces no pulse.
// - Header fields:
//   - opcode [4:0]
//   - msg_code [21:14]
//   - srcid [31:29]
//   - msg_subcode [39:32]
//   - msg_info [55:40]
//   - dstid [58:56]
// - Header check: srcid==3'b010, dstid==3'b110, opcode is 5'b10010 (no data) or 5'b11011 (with data).
// - msg_code[7:4] check:
//   - 4'h8 when test_en=1.
//   - Otherwise it must match i_state: 9/A/B/E/C for SBINIT/MBINIT/MBTRAIN/TRAINERROR_HS/PHYRETRAIN.
// - msg_code[3:0] check: 5=request (odd msg_no), A=response (even msg_no), 1=special; any other value is an error.
// - msg_no = 2k-1 for a request, 2k for a response, where k is the 1-based position of the subcode in the active list:
//   - SBINIT: {01}; msg_code 0x91 with subcode 00 -> msg_no 3.
//   - MBINIT:
//     - PARAM {00}, CAL {02}
//     - REPAIRCLK {03,04,08}, REPAIRVAL {09,0A,0C}
//     - REVERSALMB {0D,0E,0F,10}, REPAIRMB {11,13,14}
//   - MBTRAIN:
//     - VALREF {00,01}, DATAVREF {02,03}, SPEEDIDLE {04}, TXSELFCAL {05}
//     - RXCLKCAL {06,07}, VALTRAINCENTER {08,09}, VALTRAINVREF {0A,0B}
//     - DATATRAINCENTER1 {0C,0D}, DATATRAINVREF {0E,10}, RXDESKEW {11,12}, DATATRAINCENTER2 {13,14}
//     - LINKSPEED {15,16,17,18,19}; 0x19 always decodes as k=5.
//     - REPAIR {1B,1C,1D,1E}
//   - TRAINERROR_HS {00}; PHYRETRAIN {01}.
//   - Test context: TX_PT {01,02,03,04}; TX_SWEEP {05,02,06}; RX_PT {07,02,08,09}; RX_SWEEP {0A,02,0B,0D}.
//     - RX_SWEEP with msg_code 0x81 and subcode 0C -> msg_no 9.
// - Any subcode not in the active list is an error. msg_code[3:0]=1 outside the two special cases above is an error.
// - o_msg_info:
//   - msg_info[5:4] zero-extended to 3 bits when test_en=1, test is TX_PT or RX_SWEEP, and msg_no==6.
//   - Otherwise msg_info[2:0].
// - FSM IDLE:
//   - Valid no-data header: o_msg_valid pulses the next cycle (latency 1); stay IDLE.
//   - Valid with-data header: latch msg_no and msg_info, clear the timer, go WAIT_DATA; no pulse.
//   - Invalid header: o_decode_err pulses the next cycle; stay IDLE.
// - FSM WAIT_DATA:
//   - Next i_packet_valid word is payload, taken unchecked: o_data <= word; o_msg_valid and o_data_valid pulse next cycle; go IDLE.
//   - Timer counts idle cycles. At DATA_TIMEOUT with no word: o_decode_err pulses; go IDLE.
//   - A word arriving on the same cycle the timer expires is accepted as data; the timeout is suppressed.
// - o_msg_no, o_msg_info and o_data hold their values between pulses.
// - State and context inputs are sampled in the same cycle as the header word.
// TESTING
// - MBTRAIN/VALTRAINVREF: opcode 10010, msg_code 0xB5, subcode 0x0B -> next cycle o_msg_valid=1, o_msg_no=3, o_data_valid=0.
// - SBINIT: msg_code 0x91, subcode 0x00 -> o_msg_no=3. Same header with srcid=3'b011 -> o_decode_err=1 only.
// - test_en=1, TX_PT: msg_code 0x8A, subcode 0x03, msg_info=16'h0030 -> o_msg_no=6, o_msg_info=3'b011.
// - Opcode 11011 header, then 3 idle cycles, then data word 64'hDEAD_BEEF_0123_4567 -> one pulse with o_msg_valid=o_data_valid=1 and o_data equal to the word.
// - Opcode 11011 header, no data for 32 cycles -> o_decode_err=1, FSM IDLE. Repeat with i_rst_n pulsed in WAIT_DATA -> no pulses at all.
// - MBINIT/REPAIRCLK with subcode 0x05 -> o_decode_err=1; back-to-back valid headers on consecutive cycles -> two consecutive o_msg_valid pulses.

Source files
------------

// File: rtl/sb_rx_header_decoder.sv
// sb_rx_header_decoder
// Sideband RX header decoder. Turns 64-bit sideband words from the RX
// deserializer into the LTSM message view (msg_no, msg_info, optional data).
// The expected subcode list depends on the local LTSM state, sub-state and
// point/sweep test context. A message-with-data arrives as a header word
// followed by a payload word.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_packet[63:0]              received word (header in [61:0])
//   i_packet_valid              single-cycle strobe per received word
//   i_state, i_sub_state        local LTSM state / sub-state
//   i_tx_point_sweep_test_en    point/sweep test context active
//   i_tx_point_sweep_test       0=TX_PT 1=TX_SWEEP 2=RX_PT 3=RX_SWEEP
//   o_msg_no, o_msg_info        decoded message (held between pulses)
//   o_data                      payload of a message-with-data (held)
//   o_msg_valid, o_data_valid   1-cycle pulses, data_valid only with payload
//   o_decode_err                1-cycle pulse: bad header or data timeout
//   o_dbg_state                 FSM state (0=IDLE, 1=WAIT_DATA)
//
// Handshake: i_packet is qualified only by i_packet_valid; there is no
// backpressure, every strobed word is consumed in the cycle it is presented.
// Output pulses appear one cycle after the word that caused them.

module sb_rx_header_decoder #(
  parameter int DATA_TIMEOUT = 32,
  parameter int TMO_W        = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_packet,
  input  logic        i_packet_valid,
  input  logic [3:0]  i_state,
  input  logic [3:0]  i_sub_state,
  input  logic        i_tx_point_sweep_test_en,
  input  logic [1:0]  i_tx_point_sweep_test,
  output logic [3:0]  o_msg_no,
  output logic [2:0]  o_msg_info,
  output logic [63:0] o_data,
  output logic        o_msg_valid,
  output logic        o_data_valid,
  output logic        o_decode_err,
  output logic        o_dbg_state
);

  localparam logic [4:0] OP_NODATA   = 5'b10010;
  localparam logic [4:0] OP_DATA     = 5'b11011;
  localparam logic [3:0] ST_SBINIT   = 4'd2;
  localparam logic [3:0] ST_MBINIT   = 4'd3;
  localparam logic [3:0] ST_MBTRAIN  = 4'd4;
  localparam logic [3:0] ST_TRAINERR = 4'd7;
  localparam logic [3:0] ST_PHYRETR  = 4'd10;
  localparam logic [1:0] TEST_TX_PT    = 2'd0;
  localparam logic [1:0] TEST_TX_SWEEP = 2'd1;
  localparam logic [1:0] TEST_RX_PT    = 2'd2;
  localparam logic [1:0] TEST_RX_SWEEP = 2'd3;

  typedef enum logic {IDLE = 1'b0, WAIT_DATA = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmr_q, tmr_d;
  logic [3:0]        held_no_q, held_no_d;
  logic [2:0]        held_info_q, held_info_d;
  logic [3:0]        msg_no_d;
  logic [2:0]        msg_info_d;
  logic [63:0]       data_d;
  logic              msg_valid_d, data_valid_d, decode_err_d;

  // Header fields
  logic [4:0] opcode;
  logic [7:0] msg_code, subcode;
  logic [2:0] srcid, dstid;
  logic [2:0] info_lo;
  logic [1:0] info_hi;
  logic       unused_bits;

  assign opcode   = i_packet[4:0];
  assign msg_code = i_packet[21:14];
  assign srcid    = i_packet[31:29];
  assign subcode  = i_packet[39:32];
  assign info_lo  = i_packet[42:40];
  assign info_hi  = i_packet[45:44];
  assign dstid    = i_packet[58:56];
  assign unused_bits = ^{i_packet[63:59], i_packet[55:46], i_packet[43],
                         i_packet[28:22], i_packet[13:5]};

  // 1-based position of the subcode in the active list, 0 when absent.
  function automatic logic [2:0] list_pos(
    input logic       test_en,
    input logic [1:0] test,
    input logic [3:0] state,
    input logic [3:0] sub_state,
    input logic [7:0] sc
  );
    logic [2:0] k;
    k = 3'd0;
    if (test_en) begin
      case (test)
        TEST_TX_PT:
          if (sc >= 8'h01 && sc <= 8'h04) k = 3'(sc);
        TEST_TX_SWEEP:
          case (sc) 8'h05: k = 3'd1; 8'h02: k = 3'd2; 8'h06: k = 3'd3; default: k = 3'd0; endcase
        TEST_RX_PT:
          case (sc) 8'h07: k = 3'd1; 8'h02: k = 3'd2; 8'h08: k = 3'd3; 8'h09: k = 3'd4; default: k = 3'd0; endcase
        default:
          case (sc) 8'h0A: k = 3'd1; 8'h02: k = 3'd2; 8'h0B: k = 3'd3; 8'h0D: k = 3'd4; default: k = 3'd0; endcase
      endcase
    end else begin
      case (state)
        ST_SBINIT, ST_PHYRETR: if (sc == 8'h01) k = 3'd1;
        ST_TRAINERR:           if (sc == 8'h00) k = 3'd1;
        ST_MBINIT:
          case (sub_state)
            4'd0: if (sc == 8'h00) k = 3'd1;
            4'd1: if (sc == 8'h02) k = 3'd1;
            4'd2: case (sc) 8'h03: k = 3'd1; 8'h04: k = 3'd2; 8'h08: k = 3'd3; default: k = 3'd0; endcase
            4'd3: case (sc) 8'h09: k = 3'd1; 8'h0A: k = 3'd2; 8'h0C: k = 3'd3; default: k = 3'd0; endcase
            4'd4: if (sc >= 8'h0D && sc <= 8'h10) k = 3'(sc - 8'h0C);
            4'd5: case (sc) 8'h11: k = 3'd1; 8'h13: k = 3'd2; 8'h14: k = 3'd3; default: k = 3'd0; endcase
            default: k = 3'd0;
          endcase
        ST_MBTRAIN:
          case (sub_state)
            // Pairs of consecutive subcodes starting at an even base
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7:
              if (sc[7:1] == 7'({sub_state == 4'd0 ? 4'd0 : sub_state == 4'd1 ? 4'd1 :
                                 sub_state - 4'd1}))
                k = sc[0] ? 3'd2 : 3'd1;
            4'd2:  if (sc == 8'h04) k = 3'd1;
            4'd3:  if (sc == 8'h05) k = 3'd1;
            4'd8:  case (sc) 8'h0E: k = 3'd1; 8'h10: k = 3'd2; default: k = 3'd0; endcase
            4'd9:  case (sc) 8'h11: k = 3'd1; 8'h12: k = 3'd2; default: k = 3'd0; endcase
            4'd10: case (sc) 8'h13: k = 3'd1; 8'h14: k = 3'd2; default: k = 3'd0; endcase
            4'd11: if (sc >= 8'h15 && sc <= 8'h19) k = 3'(sc - 8'h14);
            4'd12: if (sc >= 8'h1B && sc <= 8'h1E) k = 3'(sc - 8'h1A);
            default: k = 3'd0;
          endcase
        default: k = 3'd0;
      endcase
    end
    return k;
  endfunction

  // Header decode
  logic [2:0] pos;
  logic       frame_ok, cls_ok, dec_ok, hdr_good, is_data_op, tmo_hit;
  logic [3:0] dec_no;
  logic [2:0] dec_info;

  always_comb begin
    pos      = list_pos(i_tx_point_sweep_test_en, i_tx_point_sweep_test,
                        i_state, i_sub_state, subcode);
    frame_ok = (srcid == 3'b010) && (dstid == 3'b110) &&
               (opcode == OP_NODATA || opcode == OP_DATA);
    cls_ok   = 1'b0;
    dec_ok   = 1'b0;
    dec_no   = 4'd0;
    if (i_tx_point_sweep_test_en) begin
      cls_ok = (msg_code[7:4] == 4'h8);
    end else begin
      case (i_state)
        ST_SBINIT:   cls_ok = (msg_code[7:4] == 4'h9);
        ST_MBINIT:   cls_ok = (msg_code[7:4] == 4'hA);
        ST_MBTRAIN:  cls_ok = (msg_code[7:4] == 4'hB);
        ST_TRAINERR: cls_ok = (msg_code[7:4] == 4'hE);
        ST_PHYRETR:  cls_ok = (msg_code[7:4] == 4'hC);
        default:     cls_ok = 1'b0;
      endcase
    end
    case (msg_code[3:0])
      4'h5: begin dec_ok = (pos != 3'd0); dec_no = {pos, 1'b0} - 4'd1; end
      4'hA: begin dec_ok = (pos != 3'd0); dec_no = {pos, 1'b0}; end
      4'h1: begin
        // Two special-cased headers; the class nibble check pins the state.
        if (!i_tx_point_sweep_test_en && msg_code == 8'h91 && subcode == 8'h00) begin
          dec_ok = 1'b1; dec_no = 4'd3;
        end else if (i_tx_point_sweep_test_en && i_tx_point_sweep_test == TEST_RX_SWEEP &&
                     msg_code == 8'h81 && subcode == 8'h0C) begin
          dec_ok = 1'b1; dec_no = 4'd9;
        end
      end
      default: dec_ok = 1'b0;
    endcase
    dec_info = (i_tx_point_sweep_test_en && dec_no == 4'd6 &&
                (i_tx_point_sweep_test == TEST_TX_PT || i_tx_point_sweep_test == TEST_RX_SWEEP))
               ? {1'b0, info_hi} : info_lo;
    hdr_good   = i_packet_valid && frame_ok && cls_ok && dec_ok;
    is_data_op = (opcode == OP_DATA);
    // A word on the expiry cycle wins over the timeout.
    tmo_hit    = !i_packet_valid && (tmr_q == TMO_W'(DATA_TIMEOUT - 1));
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      held_no_q    <= '0;
      held_info_q  <= '0;
      o_msg_no     <= '0;
      o_msg_info   <= '0;
      o_data       <= '0;
      o_msg_valid  <= 1'b0;
      o_data_valid <= 1'b0;
      o_decode_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      held_no_q    <= held_no_d;
      held_info_q  <= held_info_d;
      o_msg_no     <= msg_no_d;
      o_msg_info   <= msg_info_d;
      o_data       <= data_d;
      o_msg_valid  <= msg_valid_d;
      o_data_valid <= data_valid_d;
      o_decode_err <= decode_err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (hdr_good && is_data_op) state_d = WAIT_DATA;
      WAIT_DATA: if (i_packet_valid || tmo_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tmr_d        = tmr_q;
    held_no_d    = held_no_q;
    held_info_d  = held_info_q;
    msg_no_d     = o_msg_no;
    msg_info_d   = o_msg_info;
    data_d       = o_data;
    msg_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    decode_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_packet_valid) begin
          if (!hdr_good) begin
            decode_err_d = 1'b1;
          end else if (is_data_op) begin
            held_no_d   = dec_no;
            held_info_d = dec_info;
            tmr_d       = '0;
          end else begin
            msg_valid_d = 1'b1;
            msg_no_d    = dec_no;
            msg_info_d  = dec_info;
          end
        end
      end
      WAIT_DATA: begin
        if (i_packet_valid) begin
          data_d       = i_packet;
          msg_no_d     = held_no_q;
          msg_info_d   = held_info_q;
          msg_valid_d  = 1'b1;
          data_valid_d = 1'b1;
        end else if (tmo_hit) begin
          decode_err_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_dbg_state = state_q;

endmodule
